// File: rtl/yj_basic_pkg.sv
// ---------------------------------------------------------------------------
// yj_basic_pkg
// Shared constants and helpers for the yj_basic input-conditioning blocks.
//   YJ_SYNC_STAGES_DEF : default synchroniser depth
//   YJ_FLT_CYC_DEF     : default glitch-filter length in cycles
//   yj_clog2()         : ceiling log2, usable in parameter expressions
// ---------------------------------------------------------------------------
package yj_basic_pkg;

  localparam int YJ_SYNC_STAGES_DEF = 2;
  localparam int YJ_FLT_CYC_DEF     = 4;

  // Number of bits needed to hold values 0 .. value-1 (returns 0 for value <= 1).
  function automatic int yj_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage : yj_basic_pkg

// File: rtl/yj_basic_sync_chain.sv
// ---------------------------------------------------------------------------
// yj_basic_sync_chain
// Multi-bit synchroniser: SYNC_STAGES flops per bit, all clocked on CLK.
// Every stage resets to RST_VAL so that a quiet input held at its reset level
// looks unchanged across reset release.
// Ports:
//   CLK    : clock, rising edge
//   RSTn   : asynchronous active-low reset
//   i_din  : asynchronous inputs (DW bits)
//   o_sync : output of the last synchroniser stage (DW bits)
// ---------------------------------------------------------------------------
module yj_basic_sync_chain
  import yj_basic_pkg::*;
#(
  parameter int              DW          = 8,
  parameter int              SYNC_STAGES = YJ_SYNC_STAGES_DEF,
  parameter logic [DW-1:0]   RST_VAL     = {DW{1'b0}}
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_sync
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_depth
      $error("yj_basic_sync_chain: SYNC_STAGES must be at least 2");
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      logic [DW-1:0] r_q;
      if (gi == 0) begin : g_first
        always_ff @(posedge CLK or negedge RSTn) begin
          if (!RSTn) begin
            r_q <= RST_VAL;
          end else begin
            r_q <= i_din;
          end
        end
      end else begin : g_next
        always_ff @(posedge CLK or negedge RSTn) begin
          if (!RSTn) begin
            r_q <= RST_VAL;
          end else begin
            r_q <= g_stage[gi-1].r_q;
          end
        end
      end
    end
  endgenerate

  assign o_sync = g_stage[SYNC_STAGES-1].r_q;

endmodule : yj_basic_sync_chain

// File: rtl/yj_basic_sync_filter.sv
// ---------------------------------------------------------------------------
// yj_basic_sync_filter
// Multi-channel conditioner for asynchronous level inputs: synchroniser chain,
// optional per-channel glitch filter, registered level plus rise/fall pulses.
//
// Build option: define YJ_BASIC_SYNC_FILTER_EN to include the glitch filter.
// Without it the synchronised level is registered straight to dout (same
// timing as the filtered build with FLT_CYC = 1) and FLT_CYC is not used.
//
// Ports:
//   CLK  : clock, rising edge
//   RSTn : asynchronous active-low reset
//   din  : asynchronous inputs (DW)
//   dout : synchronised, filtered level (DW, registered)
//   rise : one-cycle pulse in the cycle dout[i] becomes 1 (DW, registered)
//   fall : one-cycle pulse in the cycle dout[i] becomes 0 (DW, registered)
//   chg  : OR of rise | fall (registered)
// ---------------------------------------------------------------------------
module yj_basic_sync_filter
  import yj_basic_pkg::*;
#(
  parameter int              DW          = 8,
  parameter int              SYNC_STAGES = YJ_SYNC_STAGES_DEF,
  parameter int              FLT_CYC     = YJ_FLT_CYC_DEF,
  parameter logic [DW-1:0]   RST_VAL     = {DW{1'b0}}
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [DW-1:0] rise,
  output logic [DW-1:0] fall,
  output logic          chg
);

  generate
    if (FLT_CYC < 1) begin : g_bad_flt
      $error("yj_basic_sync_filter: FLT_CYC must be at least 1");
    end
  endgenerate

  logic [DW-1:0] w_sync;    // last synchroniser stage
  logic [DW-1:0] w_accept;  // channels whose dout toggles at this edge

  logic [DW-1:0] r_dout;
  logic [DW-1:0] r_rise;
  logic [DW-1:0] r_fall;
  logic          r_chg;

  yj_basic_sync_chain #(
    .DW          (DW),
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (RST_VAL)
  ) u_sync (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .i_din  (din),
    .o_sync (w_sync)
  );

`ifdef YJ_BASIC_SYNC_FILTER_EN
  // Counter is at least one bit wide so FLT_CYC = 1 still elaborates; it then
  // stays at 0 and every differing sample is accepted immediately.
  localparam int              CNT_W    = (yj_clog2(FLT_CYC) < 1) ? 1 : yj_clog2(FLT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLT_CYC - 1);

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_flt
      logic [CNT_W-1:0] r_cnt;
      logic             w_diff;

      assign w_diff       = w_sync[gi] ^ r_dout[gi];
      // Accept on the FLT_CYC-th consecutive differing sample.
      assign w_accept[gi] = w_diff && (r_cnt == CNT_LAST);

      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          r_cnt <= '0;
        end else if (!w_diff || (r_cnt == CNT_LAST)) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate
`else
  assign w_accept = w_sync ^ r_dout;
`endif

  // The accepted new value equals w_sync, so its polarity picks rise vs fall.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_dout <= RST_VAL;
      r_rise <= '0;
      r_fall <= '0;
      r_chg  <= 1'b0;
    end else begin
      r_dout <= r_dout ^ w_accept;
      r_rise <= w_accept & w_sync;
      r_fall <= w_accept & ~w_sync;
      r_chg  <= |w_accept;
    end
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;
  assign chg  = r_chg;

endmodule : yj_basic_sync_filter

// File: tb/tb_yj_basic_sync_filter.sv
// ---------------------------------------------------------------------------
// tb_yj_basic_sync_filter
// Self-checking bench for yj_basic_sync_filter (DW=4, SYNC_STAGES=2,
// FLT_CYC=4, RST_VAL=0). Works for both builds of YJ_BASIC_SYNC_FILTER_EN:
// the effective filter length is 1 when the macro is undefined.
// ---------------------------------------------------------------------------
module tb_yj_basic_sync_filter;

  localparam int              DW  = 4;
  localparam int              SS  = 2;
  localparam int              FC  = 4;
  localparam logic [DW-1:0]   RV  = 4'b0000;
`ifdef YJ_BASIC_SYNC_FILTER_EN
  localparam int              FE  = FC;
`else
  localparam int              FE  = 1;
`endif
  localparam int              LAT = SS + FE;

  logic          CLK  = 1'b0;
  logic          RSTn = 1'b0;
  logic [DW-1:0] din  = '0;
  logic [DW-1:0] dout, rise, fall;
  logic          chg;

  always #5 CLK = ~CLK;

  yj_basic_sync_filter #(
    .DW          (DW),
    .SYNC_STAGES (SS),
    .FLT_CYC     (FC),
    .RST_VAL     (RV)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .chg  (chg)
  );

  int n_vec   = 0;
  int n_err   = 0;
  int step_no = 0;

  // Reference model: sync pipe as an array, plus a history of the last FE
  // synchronised samples. A channel changes when all of the last FE samples
  // differ from its current output.
  logic [DW-1:0] m_pipe [SS];
  logic [DW-1:0] m_hist [$];
  logic [DW-1:0] m_dout, m_rise, m_fall;
  logic          m_chg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at step %0d: got %h, expected %h", name, step_no, act, exp);
    end
  endtask

  task automatic model_edge(input logic [DW-1:0] d, input logic rn);
    logic [DW-1:0] s;
    logic [DW-1:0] acc;
    if (!rn) begin
      for (int k = 0; k < SS; k++) m_pipe[k] = RV;
      m_hist.delete();
      m_dout = RV;
      m_rise = '0;
      m_fall = '0;
      m_chg  = 1'b0;
    end else begin
      s = m_pipe[SS-1];
      m_hist.push_front(s);
      if (m_hist.size() > FE) void'(m_hist.pop_back());
      acc = '0;
      if (m_hist.size() == FE) begin
        for (int i = 0; i < DW; i++) begin
          acc[i] = 1'b1;
          for (int j = 0; j < m_hist.size(); j++)
            if (m_hist[j][i] == m_dout[i]) acc[i] = 1'b0;
        end
      end
      m_rise = acc & s;
      m_fall = acc & ~s;
      m_dout = m_dout ^ acc;
      m_chg  = |acc;
      for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = d;
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic step(input logic [DW-1:0] d, input logic rn);
    din  = d;
    RSTn = rn;
    @(posedge CLK);
    model_edge(d, rn);
    #1;
    step_no++;
    $display("step %0d din=%h rstn=%b dout=%h rise=%h fall=%h chg=%b",
             step_no, d, rn, dout, rise, fall, chg);
    check("model", {19'd0, dout, rise, fall, chg}, {19'd0, m_dout, m_rise, m_fall, m_chg});
  endtask

  task automatic settle(input logic [DW-1:0] d);
    for (int i = 0; i < 12; i++) step(d, 1'b1);
  endtask

  // Glitch of L cycles on din[1]; report first rise/fall edge (-1 if none).
  task automatic glitch(input int len);
    int r_e, f_e;
    r_e = -1;
    f_e = -1;
    settle('0);
    for (int e = 1; e <= 20; e++) begin
      step((e <= len) ? 4'b0010 : 4'b0000, 1'b1);
      if (rise[1] && r_e < 0) r_e = e;
      if (fall[1] && f_e < 0) f_e = e;
    end
    check($sformatf("glitch%0d_rise", len), r_e, (len >= FE) ? LAT : -1);
    check($sformatf("glitch%0d_fall", len), f_e, (len >= FE) ? len + LAT : -1);
  endtask

  typedef struct {
    logic [DW-1:0] din;
    logic          rn;
    logic [DW-1:0] e_dout;
    logic [DW-1:0] e_rise;
    logic [DW-1:0] e_fall;
    logic          e_chg;
  } vec_t;

  vec_t tbl [24];

  initial begin
    int r2, f3, nchg, r0;
    logic [DW-1:0] d;
    logic rn;

    // Reset held with din=F, then release with din=0: nothing ever moves.
    for (int i = 0; i < 4; i++)  tbl[i] = '{4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
    for (int i = 4; i < 12; i++) tbl[i] = '{4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0};
    // din[0] rises before edge 1 and is held: dout[0]/rise[0]/chg at edge LAT.
    for (int i = 12; i < 24; i++) begin
      int e;
      e = i - 11;
      tbl[i] = '{4'h1, 1'b1,
                 (e >= LAT) ? 4'h1 : 4'h0,
                 (e == LAT) ? 4'h1 : 4'h0,
                 4'h0,
                 (e == LAT)};
    end

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].din, tbl[i].rn);
      check($sformatf("tbl%0d", i), {19'd0, dout, rise, fall, chg},
            {19'd0, tbl[i].e_dout, tbl[i].e_rise, tbl[i].e_fall, tbl[i].e_chg});
    end

    // Glitch lengths around the filter threshold.
    glitch(1);
    glitch(3);
    glitch(4);

    // Simultaneous rise on ch2 and fall on ch3.
    settle(4'b1000);
    check("preset_dout3", {28'd0, dout}, 32'h8);
    r2 = -1; f3 = -1; nchg = 0;
    for (int e = 1; e <= 12; e++) begin
      step(4'b0100, 1'b1);
      if (rise[2] && r2 < 0) r2 = e;
      if (fall[3] && f3 < 0) f3 = e;
      if (chg) nchg++;
    end
    check("simul_rise2", r2, LAT);
    check("simul_fall3", f3, LAT);
    check("simul_chg_cnt", nchg, 1);

    // Reset mid-count: full latency needed again after release.
    settle('0);
    for (int e = 1; e <= 3; e++) step(4'b0001, 1'b1);
    step(4'b0001, 1'b0);
    check("rst_dout0", {31'd0, dout[0]}, 32'd0);
    r0 = -1;
    for (int e = 5; e <= 16; e++) begin
      step(4'b0001, 1'b1);
      if (rise[0] && r0 < 0) r0 = e;
    end
    check("rst_rise0", r0, 4 + LAT);

    // Randomised stimulus against the model.
    d = '0;
    for (int i = 0; i < 200; i++) begin
      for (int b = 0; b < DW; b++)
        if ($urandom_range(0, 3) == 0) d[b] = ~d[b];
      rn = ($urandom_range(0, 49) != 0);
      step(d, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_yj_basic_sync_filter
